// File: rtl/near_path_seq.sv
// Near-path subtractor for the dual-path FP adder: exact subtraction of close
// exponents, stepwise coarse/fine normalization, then round-to-nearest-even.
module near_path_seq #(
  parameter int SIZE_IN_MANTISSA = 24,
  parameter int SIZE_EXPONENT    = 8,
  parameter int SHIFT_STEP       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        ready,
  input  logic [SIZE_IN_MANTISSA-1:0] m_a_number,
  input  logic [SIZE_IN_MANTISSA-1:0] m_b_number,
  input  logic                        exp_difference,
  input  logic [SIZE_EXPONENT:0]      exp_inter,
  input  logic                        out_ready,
  output logic                        valid_o,
  output logic [SIZE_IN_MANTISSA-1:0] resulted_m_o,
  output logic [SIZE_EXPONENT-1:0]    resulted_e_o,
  output logic                        sign_swap_o,
  output logic                        zero_o,
  output logic                        underflow_o
);

  localparam int WW = SIZE_IN_MANTISSA + 1;
  localparam int DW = SIZE_IN_MANTISSA + 2;
  localparam logic [SIZE_EXPONENT:0] STEP_EXP = SHIFT_STEP[SIZE_EXPONENT:0];
  localparam logic [SIZE_EXPONENT:0] ONE_EXP  = {{SIZE_EXPONENT{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, SUB, COARSE, FINE, ROUND, DONE} state_t;

  state_t                      state_q;
  logic [SIZE_IN_MANTISSA-1:0] mA_q;
  logic [SIZE_IN_MANTISSA-1:0] mB_q;
  logic                        expDiff_q;
  logic [SIZE_EXPONENT:0]      expWork_q;
  logic [WW-1:0]               work_q;

  logic [DW-1:0]               aExt_d;
  logic [DW-1:0]               bExt_d;
  logic [DW-1:0]               diff_d;
  logic [DW-1:0]               absDiff_d;
  logic                        negative_d;
  logic                        isZero_d;
  logic                        coarseShift_d;
  logic                        fineShift_d;
  logic [SIZE_IN_MANTISSA-1:0] mant_d;
  logic                        roundUp_d;
  logic [SIZE_IN_MANTISSA:0]   rounded_d;
  logic [SIZE_EXPONENT-1:0]    expInc_d;

  // B is pre-shifted right by one position when its exponent is one smaller;
  // the extra low bit keeps the difference exact and becomes the guard bit.
  always_comb begin
    aExt_d        = {1'b0, mA_q, 1'b0};
    bExt_d        = expDiff_q ? {2'b00, mB_q} : {1'b0, mB_q, 1'b0};
    diff_d        = aExt_d - bExt_d;
    negative_d    = diff_d[DW-1];
    absDiff_d     = negative_d ? (-diff_d) : diff_d;
    isZero_d      = (absDiff_d == '0);
    coarseShift_d = (work_q[WW-1 -: SHIFT_STEP] == '0) && (expWork_q > STEP_EXP);
    fineShift_d   = !work_q[WW-1] && (expWork_q > ONE_EXP);
    mant_d        = work_q[WW-1:1];
    roundUp_d     = work_q[0] & mant_d[0];
    rounded_d     = {1'b0, mant_d} + {{SIZE_IN_MANTISSA{1'b0}}, roundUp_d};
    expInc_d      = expWork_q[SIZE_EXPONENT-1:0] + {{(SIZE_EXPONENT-1){1'b0}}, 1'b1};
  end

  // Control and datapath share one sequential block so every output is a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ready        <= 1'b1;
      valid_o      <= 1'b0;
      resulted_m_o <= '0;
      resulted_e_o <= '0;
      sign_swap_o  <= 1'b0;
      zero_o       <= 1'b0;
      underflow_o  <= 1'b0;
      mA_q         <= '0;
      mB_q         <= '0;
      expDiff_q    <= 1'b0;
      expWork_q    <= '0;
      work_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mA_q        <= m_a_number;
            mB_q        <= m_b_number;
            expDiff_q   <= exp_difference;
            expWork_q   <= exp_inter;
            ready       <= 1'b0;
            sign_swap_o <= 1'b0;
            zero_o      <= 1'b0;
            underflow_o <= 1'b0;
            state_q     <= SUB;
          end
        end
        SUB: begin
          work_q      <= absDiff_d[WW-1:0];
          sign_swap_o <= negative_d;
          if (isZero_d) begin
            resulted_m_o <= '0;
            resulted_e_o <= '0;
            zero_o       <= 1'b1;
            valid_o      <= 1'b1;
            state_q      <= DONE;
          end else begin
            state_q <= COARSE;
          end
        end
        COARSE: begin
          if (coarseShift_d) begin
            work_q    <= work_q << SHIFT_STEP;
            expWork_q <= expWork_q - STEP_EXP;
          end else begin
            state_q <= FINE;
          end
        end
        // Exponent 1 with the MSB still clear cannot be normalized further.
        FINE: begin
          if (work_q[WW-1]) begin
            state_q <= ROUND;
          end else if (fineShift_d) begin
            work_q    <= work_q << 1;
            expWork_q <= expWork_q - ONE_EXP;
          end else begin
            underflow_o  <= 1'b1;
            resulted_m_o <= '0;
            resulted_e_o <= '0;
            valid_o      <= 1'b1;
            state_q      <= DONE;
          end
        end
        ROUND: begin
          if (rounded_d[SIZE_IN_MANTISSA]) begin
            resulted_m_o <= {1'b1, {(SIZE_IN_MANTISSA-1){1'b0}}};
            resulted_e_o <= expInc_d;
          end else begin
            resulted_m_o <= rounded_d[SIZE_IN_MANTISSA-1:0];
            resulted_e_o <= expWork_q[SIZE_EXPONENT-1:0];
          end
          valid_o <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            valid_o <= 1'b0;
            ready   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_o <= 1'b0;
          ready   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_near_path_seq.sv
// Self-checking bench for near_path_seq: integer reference model, per-cycle
// output comparison, latency checks, handshake stall and reset behaviour.
module tb_near_path_seq;

  localparam int M = 24;
  localparam int E = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         ready;
  logic [M-1:0] m_a_number;
  logic [M-1:0] m_b_number;
  logic         exp_difference;
  logic [E:0]   exp_inter;
  logic         out_ready;
  logic         valid_o;
  logic [M-1:0] resulted_m_o;
  logic [E-1:0] resulted_e_o;
  logic         sign_swap_o;
  logic         zero_o;
  logic         underflow_o;

  int checks = 0;
  int errors = 0;

  bit           expectActive = 1'b0;
  logic [M-1:0] expM;
  logic [E-1:0] expE;
  logic         expSwap;
  logic         expZero;
  logic         expUf;

  near_path_seq #(.SIZE_IN_MANTISSA(M), .SIZE_EXPONENT(E), .SHIFT_STEP(4)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready),
    .m_a_number(m_a_number), .m_b_number(m_b_number),
    .exp_difference(exp_difference), .exp_inter(exp_inter),
    .out_ready(out_ready), .valid_o(valid_o),
    .resulted_m_o(resulted_m_o), .resulted_e_o(resulted_e_o),
    .sign_swap_o(sign_swap_o), .zero_o(zero_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  // Reference: exact integer difference, leading-zero count, then the shift
  // budget allowed by the exponent, then RNE on the single guard bit.
  task automatic modelCompute(input logic [M-1:0] ma, input logic [M-1:0] mb,
                              input logic diff, input int ex,
                              output logic [M-1:0] m, output logic [E-1:0] e,
                              output logic sw, output logic z, output logic uf,
                              output int lat);
    longint a, b, d, w, mant;
    int lz, nc, nf, lr, ew;
    a  = 2 * longint'(ma);
    b  = diff ? longint'(mb) : 2 * longint'(mb);
    d  = a - b;
    sw = (d < 0);
    w  = sw ? -d : d;
    z  = 1'b0;
    uf = 1'b0;
    m  = '0;
    e  = '0;
    if (w == 0) begin
      z   = 1'b1;
      lat = 2;
      return;
    end
    lz = 0;
    while (((w >> (24 - lz)) & 1) == 0) lz++;
    nc = 0;
    while ((lz - 4 * nc >= 4) && (ex - 4 * nc > 4)) nc++;
    lr = lz - 4 * nc;
    ew = ex - 4 * nc;
    if (lr <= ew - 1) begin
      nf = lr;
      ew = ew - lr;
      w  = w << lz;
      mant = w >> 1;
      if (((w & 1) == 1) && ((mant & 1) == 1)) mant++;
      if (mant == (longint'(1) << 24)) begin
        mant = longint'(1) << 23;
        ew++;
      end
      m   = mant[M-1:0];
      e   = ew[E-1:0];
      lat = 5 + nc + nf;
    end else begin
      nf  = ew - 1;
      uf  = 1'b1;
      lat = 4 + nc + nf;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  // Per-cycle comparison of DUT outputs against the active model result.
  always @(negedge clk) begin
    if (expectActive) begin
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL busy_ready: got %b, expected 0", ready);
      end
      if (valid_o === 1'b1) begin
        checks++;
        if ({resulted_m_o, resulted_e_o, sign_swap_o, zero_o, underflow_o} !==
            {expM, expE, expSwap, expZero, expUf}) begin
          errors++;
          $display("[TB] FAIL result: got m=%h e=%0d swap=%b zero=%b uf=%b, expected m=%h e=%0d swap=%b zero=%b uf=%b",
                   resulted_m_o, resulted_e_o, sign_swap_o, zero_o, underflow_o,
                   expM, expE, expSwap, expZero, expUf);
        end
      end
    end else begin
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL spurious_valid: got %b, expected 0", valid_o);
      end
    end
  end

  task automatic applyStimulus(input logic [M-1:0] ma, input logic [M-1:0] mb, input logic diff,
                               input int ex, input int hold,
                               input logic [M-1:0] hm, input logic [E-1:0] he,
                               input logic hs, input logic hz, input logic hu, input int hl);
    logic [M-1:0] mm;
    logic [E-1:0] me;
    logic ms, mz, mu;
    int ml, j;
    bit got;
    modelCompute(ma, mb, diff, ex, mm, me, ms, mz, mu, ml);
    checks++;
    if ({mm, me, ms, mz, mu} !== {hm, he, hs, hz, hu} || ml != hl) begin
      errors++;
      $display("[TB] FAIL model_pin: got m=%h e=%0d lat=%0d, expected m=%h e=%0d lat=%0d", mm, me, ml, hm, he, hl);
    end
    expM = mm; expE = me; expSwap = ms; expZero = mz; expUf = mu;
    @(negedge clk);
    checkOutput("ready_idle", {31'd0, ready}, 32'd1);
    m_a_number = ma; m_b_number = mb; exp_difference = diff; exp_inter = ex[E:0];
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    expectActive = 1'b1;
    j = 0;
    got = 1'b0;
    while (j < 200) begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      j++;
    end
    checkOutput("latency", got ? j + 1 : -1, ml);
    if (!got) begin
      expectActive = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      return;
    end
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      start = 1'b1;
      m_a_number = 24'($urandom);
      m_b_number = 24'($urandom);
      @(negedge clk);
    end
    out_ready = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b0;
    expectActive = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_hs", {31'd0, ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    m_a_number = '0; m_b_number = '0; exp_difference = 1'b0; exp_inter = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ready", {31'd0, ready}, 32'd1);
    checkOutput("reset_outputs", {resulted_m_o, resulted_e_o}, 32'd0);
    checkOutput("reset_flags", {29'd0, sign_swap_o, zero_o, underflow_o}, 32'd0);
    rst = 1'b0;

    applyStimulus(24'hC00000, 24'h800000, 1'b0, 130, 0, 24'h800000, 8'd129, 1'b0, 1'b0, 1'b0, 6);
    applyStimulus(24'h800000, 24'hC00000, 1'b0, 130, 0, 24'h800000, 8'd129, 1'b1, 1'b0, 1'b0, 6);
    applyStimulus(24'hABCDEF, 24'hABCDEF, 1'b0, 130, 0, 24'h000000, 8'd0,   1'b0, 1'b1, 1'b0, 2);
    applyStimulus(24'h800000, 24'hFFFFFF, 1'b1, 130, 0, 24'h800000, 8'd106, 1'b0, 1'b0, 1'b0, 11);
    applyStimulus(24'hFFFFFF, 24'h800001, 1'b1, 130, 0, 24'hBFFFFE, 8'd130, 1'b0, 1'b0, 1'b0, 5);
    applyStimulus(24'hFFFFFF, 24'h800003, 1'b1, 130, 0, 24'hBFFFFE, 8'd130, 1'b0, 1'b0, 1'b0, 5);
    applyStimulus(24'h800000, 24'hFFFFFF, 1'b1, 3,   5, 24'h000000, 8'd0,   1'b0, 1'b0, 1'b1, 6);
    applyStimulus(24'h800000, 24'hFFFFFF, 1'b1, 25,  0, 24'h800000, 8'd1,   1'b0, 1'b0, 1'b0, 11);
    applyStimulus(24'h800000, 24'hFFFFFF, 1'b1, 24,  0, 24'h000000, 8'd0,   1'b0, 1'b0, 1'b1, 12);
    applyStimulus(24'h800000, 24'hFFFFFF, 1'b1, 10,  0, 24'h000000, 8'd0,   1'b0, 1'b0, 1'b1, 7);
    applyStimulus(24'h800001, 24'h800000, 1'b0, 130, 2, 24'h800000, 8'd107, 1'b0, 1'b0, 1'b0, 13);
    applyStimulus(24'hC00002, 24'h800001, 1'b1, 130, 0, 24'h800002, 8'd130, 1'b0, 1'b0, 1'b0, 5);

    // Reset while normalizing: the in-flight operation must vanish.
    @(negedge clk);
    m_a_number = 24'h800000; m_b_number = 24'hFFFFFF; exp_difference = 1'b1; exp_inter = 9'd130;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("busy_before_rst", {31'd0, ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_ready", {31'd0, ready}, 32'd1);
    checkOutput("rst_mid_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("rst_mid_outputs", {resulted_m_o, resulted_e_o}, 32'd0);

    // Reset and start together: nothing may be captured.
    rst = 1'b1; start = 1'b1;
    m_a_number = 24'hC00000; m_b_number = 24'h800000; exp_difference = 1'b0; exp_inter = 9'd130;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checkOutput("rst_start_ready", {31'd0, ready}, 32'd1);
    repeat (8) @(negedge clk);
    checkOutput("rst_start_idle", {30'd0, ready, valid_o}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
